riscv_bif_arb: RTL and testbench

//  Two-master, single-outstanding arbiter: shares one memory port (mem_bif_*) between

---
 rtl/riscv_bif_arb.sv | 131 +++++++++++++
 tb/tb_riscv_bif_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_bif_arb.sv
// Two-master, single-outstanding arbiter sharing one memory port between
// instruction fetch and the data pipe, with starvation limit and bus timeout.
module riscv_bif_arb #(
  parameter bit          DATA_PRIO  = 1'b1,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_bif_req,
  input  logic [31:0] inst_bif_addr,
  output logic        inst_bif_ack,
  output logic [31:0] inst_bif_rdata,
  input  logic        data_bif_req,
  input  logic [31:0] data_bif_addr,
  input  logic        data_bif_rnw,
  input  logic [3:0]  data_bif_wmask,
  input  logic [31:0] data_bif_wdata,
  output logic        data_bif_ack,
  output logic [31:0] data_bif_rdata,
  output logic        mem_bif_req,
  output logic [31:0] mem_bif_addr,
  output logic        mem_bif_rnw,
  output logic [3:0]  mem_bif_wmask,
  output logic [31:0] mem_bif_wdata,
  input  logic [31:0] mem_bif_rdata,
  input  logic        mem_bif_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0]  STARVE_MAX  = 4'(MAX_STARVE);
  localparam logic [7:0]  TIMEOUT_CYC = 8'(TIMEOUT);
  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [7:0]  to_cnt;
  logic        grant, pick_data, timeout, done;
  logic [31:0] ack_rdata, inst_rdata_q, data_rdata_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant      = 1'b0;
    pick_data  = 1'b0;
    timeout    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (inst_bif_req || data_bif_req) begin
          grant = 1'b1;
          if (inst_bif_req && data_bif_req) begin
            // The waiting side is let through once the favoured side has had its run.
            if (starve_cnt >= STARVE_MAX) begin
              pick_data  = !DATA_PRIO;
              starve_nxt = '0;
            end else begin
              pick_data  = DATA_PRIO;
              starve_nxt = starve_cnt + 4'd1;
            end
          end else begin
            pick_data  = data_bif_req;
            starve_nxt = '0;
          end
          state_nxt = pick_data ? DATA : INST;
        end
      end
      default: begin
        // A real ack always beats a timeout landing in the same cycle.
        timeout = (TIMEOUT_CYC != 8'd0) && !mem_bif_ack && (to_cnt == TIMEOUT_CYC);
        done    = mem_bif_ack || timeout;
        if (done) state_nxt = IDLE;
      end
    endcase
  end

  assign ack_rdata      = timeout ? ERR_RDATA : mem_bif_rdata;
  assign inst_bif_ack   = done && (state == INST);
  assign data_bif_ack   = done && (state == DATA);
  assign inst_bif_rdata = inst_bif_ack ? ack_rdata : inst_rdata_q;
  assign data_bif_rdata = data_bif_ack ? ack_rdata : data_rdata_q;
  assign bus_err        = timeout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      to_cnt        <= '0;
      mem_bif_req   <= 1'b0;
      mem_bif_addr  <= '0;
      mem_bif_rnw   <= 1'b1;
      mem_bif_wmask <= '0;
      mem_bif_wdata <= '0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant) begin
        mem_bif_req <= 1'b1;
        to_cnt      <= '0;
        if (pick_data) begin
          mem_bif_addr  <= data_bif_addr;
          mem_bif_rnw   <= data_bif_rnw;
          mem_bif_wmask <= data_bif_wmask;
          mem_bif_wdata <= data_bif_wdata;
        end else begin
          mem_bif_addr  <= inst_bif_addr;
          mem_bif_rnw   <= 1'b1;
          mem_bif_wmask <= '0;
          mem_bif_wdata <= '0;
        end
      end else if (done) begin
        mem_bif_req <= 1'b0;
      end else if (mem_bif_req) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (inst_bif_ack) inst_rdata_q <= ack_rdata;
      if (data_bif_ack) data_rdata_q <= ack_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_bif_arb.sv
// Bench for riscv_bif_arb: directed scenarios, then randomized two-master
// traffic scored against a transaction-level arbitration model.
module tb_riscv_bif_arb;

  localparam int MAX_STARVE = 4;
  localparam int TIMEOUT    = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk, rst;
  logic        inst_bif_req, inst_bif_ack;
  logic [31:0] inst_bif_addr, inst_bif_rdata;
  logic        data_bif_req, data_bif_rnw, data_bif_ack;
  logic [31:0] data_bif_addr, data_bif_wdata, data_bif_rdata;
  logic [3:0]  data_bif_wmask;
  logic        mem_bif_req, mem_bif_rnw, mem_bif_ack, bus_err;
  logic [31:0] mem_bif_addr, mem_bif_wdata, mem_bif_rdata;
  logic [3:0]  mem_bif_wmask;

  riscv_bif_arb #(
    .DATA_PRIO (1'b1),
    .MAX_STARVE(MAX_STARVE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_bif_req  (inst_bif_req),
    .inst_bif_addr (inst_bif_addr),
    .inst_bif_ack  (inst_bif_ack),
    .inst_bif_rdata(inst_bif_rdata),
    .data_bif_req  (data_bif_req),
    .data_bif_addr (data_bif_addr),
    .data_bif_rnw  (data_bif_rnw),
    .data_bif_wmask(data_bif_wmask),
    .data_bif_wdata(data_bif_wdata),
    .data_bif_ack  (data_bif_ack),
    .data_bif_rdata(data_bif_rdata),
    .mem_bif_req   (mem_bif_req),
    .mem_bif_addr  (mem_bif_addr),
    .mem_bif_rnw   (mem_bif_rnw),
    .mem_bif_wmask (mem_bif_wmask),
    .mem_bif_wdata (mem_bif_wdata),
    .mem_bif_rdata (mem_bif_rdata),
    .mem_bif_ack   (mem_bif_ack),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_bif_req   = 1'b0;
    inst_bif_addr  = '0;
    data_bif_req   = 1'b0;
    data_bif_addr  = '0;
    data_bif_rnw   = 1'b1;
    data_bif_wmask = '0;
    data_bif_wdata = '0;
    mem_bif_ack    = 1'b0;
    mem_bif_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_mem(input string tag, input xfer_t e);
    check({tag, "_req"},   32'(mem_bif_req),   32'd1);
    check({tag, "_addr"},  mem_bif_addr,       e.addr);
    check({tag, "_rnw"},   32'(mem_bif_rnw),   32'(e.rnw));
    check({tag, "_wmask"}, 32'(mem_bif_wmask), 32'(e.wmask));
    check({tag, "_wdata"}, mem_bif_wdata,      e.wdata);
  endtask

  // Random-phase model state
  xfer_t       ireq, dreq, exp_x;
  int          owner, streak, mwait;
  logic        p_ireq, p_dreq, p_mreq, p_mack, iack_exp, dack_exp;
  logic        have_ir, have_dr;
  logic [31:0] last_ir, last_dr;

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    do_reset();

    // Reset state
    look();
    check("rst_req",   32'(mem_bif_req),   32'd0);
    check("rst_addr",  mem_bif_addr,       32'd0);
    check("rst_rnw",   32'(mem_bif_rnw),   32'd1);
    check("rst_wmask", 32'(mem_bif_wmask), 32'd0);
    check("rst_wdata", mem_bif_wdata,      32'd0);
    check("rst_iack",  32'(inst_bif_ack),  32'd0);
    check("rst_dack",  32'(data_bif_ack),  32'd0);
    check("rst_err",   32'(bus_err),       32'd0);

    // Memory ack while idle is ignored
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'hFFFF_0000;
    look();
    check("idle_ack_iack", 32'(inst_bif_ack), 32'd0);
    check("idle_ack_dack", 32'(data_bif_ack), 32'd0);
    tick(); mem_bif_ack = 1'b0;
    look();
    check("idle_ack_req", 32'(mem_bif_req), 32'd0);

    // Inst read, memory ack two cycles after the port request rises
    tick(); inst_bif_req = 1'b1; inst_bif_addr = 32'h100;
    look();
    check("t1_t0_req", 32'(mem_bif_req), 32'd0);
    tick(); look();
    check_mem("t1_t1", '{addr: 32'h100, rnw: 1'b1, wmask: 4'h0, wdata: 32'h0});
    tick(); look();
    check("t1_t2_req",  32'(mem_bif_req),  32'd1);
    check("t1_t2_iack", 32'(inst_bif_ack), 32'd0);
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'h1234_5678;
    look();
    check("t1_t3_iack",   32'(inst_bif_ack), 32'd1);
    check("t1_t3_irdata", inst_bif_rdata,    32'h1234_5678);
    check("t1_t3_dack",   32'(data_bif_ack), 32'd0);
    tick(); mem_bif_ack = 1'b0; mem_bif_rdata = 32'h0; inst_bif_req = 1'b0;
    look();
    check("t1_t4_req",   32'(mem_bif_req),  32'd0);
    check("t1_t4_iack",  32'(inst_bif_ack), 32'd0);
    check("t1_t4_ihold", inst_bif_rdata,    32'h1234_5678);

    // Data write: registered fields stay put while the requester's inputs move
    tick();
    data_bif_req = 1'b1; data_bif_addr = 32'h200; data_bif_rnw = 1'b0;
    data_bif_wmask = 4'b0011; data_bif_wdata = 32'hAABB_CCDD;
    look();
    tick();
    data_bif_addr = 32'h999; data_bif_wmask = 4'hF; data_bif_wdata = 32'h0;
    look();
    check_mem("t4_a", '{addr: 32'h200, rnw: 1'b0, wmask: 4'b0011, wdata: 32'hAABB_CCDD});
    tick(); look();
    check_mem("t4_b", '{addr: 32'h200, rnw: 1'b0, wmask: 4'b0011, wdata: 32'hAABB_CCDD});
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'h55;
    look();
    check("t4_dack",   32'(data_bif_ack), 32'd1);
    check("t4_iack",   32'(inst_bif_ack), 32'd0);
    check("t4_drdata", data_bif_rdata,    32'h55);
    check("t4_ihold",  inst_bif_rdata,    32'h1234_5678);
    tick(); mem_bif_ack = 1'b0; data_bif_req = 1'b0; data_bif_rnw = 1'b1;
    look();
    check("t4_end_req", 32'(mem_bif_req), 32'd0);

    // Simultaneous requests: data first, inst only after an idle gap
    tick();
    inst_bif_req = 1'b1; inst_bif_addr = 32'h300;
    data_bif_req = 1'b1; data_bif_addr = 32'h400; data_bif_wmask = 4'h0;
    look();
    tick(); look();
    check("t2_first_addr", mem_bif_addr,      32'h400);
    check("t2_first_req",  32'(mem_bif_req),  32'd1);
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'hA1;
    look();
    check("t2_dack",   32'(data_bif_ack), 32'd1);
    check("t2_iack0",  32'(inst_bif_ack), 32'd0);
    check("t2_drdata", data_bif_rdata,    32'hA1);
    tick(); mem_bif_ack = 1'b0; data_bif_req = 1'b0;
    look();
    check("t2_gap_req",  32'(mem_bif_req), 32'd0);
    check("t2_gap_addr", mem_bif_addr,     32'h400);
    tick(); look();
    check_mem("t2_second", '{addr: 32'h300, rnw: 1'b1, wmask: 4'h0, wdata: 32'h0});
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'hB2;
    look();
    check("t2_iack",   32'(inst_bif_ack), 32'd1);
    check("t2_irdata", inst_bif_rdata,    32'hB2);
    check("t2_dack0",  32'(data_bif_ack), 32'd0);
    tick(); mem_bif_ack = 1'b0; inst_bif_req = 1'b0;
    look();

    // Starvation limit: four data grants, then inst, then data again
    do_reset();
    data_bif_req = 1'b1; data_bif_addr = 32'h1000; data_bif_rnw = 1'b1;
    inst_bif_req = 1'b1; inst_bif_addr = 32'h2000;
    begin
      logic [31:0] exp_seq [6];
      logic        drop, seen, is_inst;
      exp_seq = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h2000, 32'h1000};
      drop = 1'b0;
      for (int k = 0; k < 6; k++) begin
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
          tick();
          mem_bif_ack = 1'b0;
          if (drop) inst_bif_req = 1'b0;
          drop = 1'b0;
          look();
          seen = mem_bif_req;
        end
        check($sformatf("t3_req%0d", k),  32'(mem_bif_req), 32'd1);
        check($sformatf("t3_addr%0d", k), mem_bif_addr,     exp_seq[k]);
        is_inst = (exp_seq[k] == 32'h2000);
        tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'(k);
        look();
        check($sformatf("t3_iack%0d", k), 32'(inst_bif_ack), 32'(is_inst));
        check($sformatf("t3_dack%0d", k), 32'(data_bif_ack), 32'(!is_inst));
        drop = is_inst;
      end
    end
    tick(); mem_bif_ack = 1'b0; data_bif_req = 1'b0; inst_bif_req = 1'b0;
    look();

    // Timeout abort, then a normal transaction, then ack landing on the timeout cycle
    do_reset();
    inst_bif_req = 1'b1; inst_bif_addr = 32'h500;
    look();
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick(); look();
      check($sformatf("t5_wait%0d_req", i), 32'(mem_bif_req), 32'd1);
      check($sformatf("t5_wait%0d_err", i), 32'(bus_err),     32'd0);
    end
    tick(); look();
    check("t5_err",    32'(bus_err),       32'd1);
    check("t5_iack",   32'(inst_bif_ack),  32'd1);
    check("t5_irdata", inst_bif_rdata,     32'hDEAD_BEEF);
    check("t5_dack",   32'(data_bif_ack),  32'd0);
    tick(); inst_bif_req = 1'b0; data_bif_req = 1'b1; data_bif_addr = 32'h600;
    look();
    check("t5_gap_req", 32'(mem_bif_req), 32'd0);
    check("t5_gap_err", 32'(bus_err),     32'd0);
    tick(); look();
    check("t5_next_addr", mem_bif_addr, 32'h600);
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'h0BAD_F00D;
    look();
    check("t5_next_dack",   32'(data_bif_ack), 32'd1);
    check("t5_next_drdata", data_bif_rdata,    32'h0BAD_F00D);
    check("t5_next_err",    32'(bus_err),      32'd0);
    tick(); mem_bif_ack = 1'b0; data_bif_addr = 32'h700;
    look();
    for (int i = 0; i < TIMEOUT; i++) begin
      tick(); look();
      check($sformatf("t5b_wait%0d_err", i), 32'(bus_err), 32'd0);
    end
    tick(); mem_bif_ack = 1'b1; mem_bif_rdata = 32'h600D_CAFE;
    look();
    check("t5b_err",    32'(bus_err),      32'd0);
    check("t5b_dack",   32'(data_bif_ack), 32'd1);
    check("t5b_drdata", data_bif_rdata,    32'h600D_CAFE);
    tick(); mem_bif_ack = 1'b0; data_bif_req = 1'b0;
    look();
    check("t5b_end_req", 32'(mem_bif_req), 32'd0);

    // Asynchronous reset while a data transaction is pending
    tick(); data_bif_req = 1'b1; data_bif_addr = 32'h800; data_bif_rnw = 1'b1;
    look();
    tick(); look();
    check("t6_pend_req", 32'(mem_bif_req), 32'd1);
    #1;
    rst = 1'b1; mem_bif_ack = 1'b1; mem_bif_rdata = 32'h1;
    #1;
    check("t6_async_req",  32'(mem_bif_req),  32'd0);
    check("t6_async_addr", mem_bif_addr,      32'd0);
    check("t6_async_rnw",  32'(mem_bif_rnw),  32'd1);
    check("t6_async_dack", 32'(data_bif_ack), 32'd0);
    check("t6_async_err",  32'(bus_err),      32'd0);
    tick(); rst = 1'b0; mem_bif_ack = 1'b0; data_bif_req = 1'b0;
    look();
    check("t6_post_req",  32'(mem_bif_req),  32'd0);
    check("t6_post_dack", 32'(data_bif_ack), 32'd0);

    // Randomized two-master traffic
    do_reset();
    owner = 0; streak = 0; mwait = int'($urandom_range(0, 4));
    p_ireq = 1'b0; p_dreq = 1'b0; p_mreq = 1'b0; p_mack = 1'b0;
    have_ir = 1'b0; have_dr = 1'b0; last_ir = '0; last_dr = '0;
    ireq = '0; dreq = '0; exp_x = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      look();
      check("r_req", 32'(mem_bif_req), 32'(p_mreq ? !p_mack : (p_ireq | p_dreq)));
      if (mem_bif_req && !p_mreq) begin
        if (p_ireq && p_dreq) begin
          if (streak == MAX_STARVE) begin
            owner  = 1;
            streak = 0;
          end else begin
            owner  = 2;
            streak = streak + 1;
          end
        end else begin
          owner  = p_dreq ? 2 : 1;
          streak = 0;
        end
        exp_x = (owner == 2) ? dreq : ireq;
      end
      if (mem_bif_req) check_mem("r_mem", exp_x);
      iack_exp = mem_bif_req && mem_bif_ack && (owner == 1);
      dack_exp = mem_bif_req && mem_bif_ack && (owner == 2);
      check("r_iack", 32'(inst_bif_ack), 32'(iack_exp));
      check("r_dack", 32'(data_bif_ack), 32'(dack_exp));
      if (iack_exp) begin
        last_ir = mem_f(exp_x.addr);
        have_ir = 1'b1;
        check("r_irdata", inst_bif_rdata, last_ir);
      end else if (have_ir) begin
        check("r_ihold", inst_bif_rdata, last_ir);
      end
      if (dack_exp) begin
        last_dr = mem_f(exp_x.addr);
        have_dr = 1'b1;
        check("r_drdata", data_bif_rdata, last_dr);
      end else if (have_dr) begin
        check("r_dhold", data_bif_rdata, last_dr);
      end
      check("r_err", 32'(bus_err), 32'd0);
      p_ireq = inst_bif_req; p_dreq = data_bif_req;
      p_mreq = mem_bif_req;  p_mack = mem_bif_ack;

      tick();
      if (iack_exp || (!inst_bif_req && $urandom_range(0, 2) == 0)) begin
        inst_bif_req = iack_exp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inst_bif_req)
          ireq = '{addr: $urandom & 32'hFFFF_FFFC, rnw: 1'b1, wmask: 4'h0, wdata: 32'h0};
      end
      if (dack_exp || (!data_bif_req && $urandom_range(0, 2) == 0)) begin
        data_bif_req = dack_exp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (data_bif_req)
          dreq = '{addr: $urandom, rnw: 1'($urandom_range(0, 1)),
                   wmask: 4'($urandom), wdata: $urandom};
      end
      inst_bif_addr  = ireq.addr;
      data_bif_addr  = dreq.addr;
      data_bif_rnw   = dreq.rnw;
      data_bif_wmask = dreq.wmask;
      data_bif_wdata = dreq.wdata;
      mem_bif_ack    = 1'b0;
      mem_bif_rdata  = $urandom;
      if (mem_bif_req) begin
        if (mwait == 0) begin
          mem_bif_ack   = 1'b1;
          mem_bif_rdata = mem_f(mem_bif_addr);
          mwait         = int'($urandom_range(0, 4));
        end else begin
          mwait = mwait - 1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_bif_ack = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
